// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the encoder (and the matching decoder).
// Contents: instruction class codes, 5-bit major opcodes (opcode[6:2]),
// format enum, encoder request payload, signed-range helper.
package rv32i_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [3:0] {
        CLS_LOAD     = 4'd0,
        CLS_STORE    = 4'd1,
        CLS_MEMORDER = 4'd2,
        CLS_ALUREG   = 4'd3,
        CLS_ALUIMM   = 4'd4,
        CLS_LUI      = 4'd5,
        CLS_AUIPC    = 4'd6,
        CLS_JAL      = 4'd7,
        CLS_JALR     = 4'd8,
        CLS_BRANCH   = 4'd9,
        CLS_SYSCALL  = 4'd10
    } inst_class_e;

    localparam logic [4:0] OP_LOAD     = 5'b00000;
    localparam logic [4:0] OP_STORE    = 5'b01000;
    localparam logic [4:0] OP_MEMORDER = 5'b00011;
    localparam logic [4:0] OP_ALUREG   = 5'b01100;
    localparam logic [4:0] OP_ALUIMM   = 5'b00100;
    localparam logic [4:0] OP_LUI      = 5'b01101;
    localparam logic [4:0] OP_AUIPC    = 5'b00101;
    localparam logic [4:0] OP_JAL      = 5'b11011;
    localparam logic [4:0] OP_JALR     = 5'b11001;
    localparam logic [4:0] OP_BRANCH   = 5'b11000;
    localparam logic [4:0] OP_SYSCALL  = 5'b11100;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
    } inst_fmt_e;

    // cls kept as raw code so illegal values 11-15 pass through unchanged
    typedef struct packed {
        logic [3:0]        cls;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [INST_W-1:0] imm;
    } enc_req_t;

    // True when v[31:msb] are all equal, i.e. v fits a (msb+1)-bit signed field
    function automatic logic fits_signed(input logic [INST_W-1:0] v, input int unsigned msb);
        logic [INST_W-1:0] s;
        s = INST_W'($signed(v) >>> msb);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/rv32i_encode_comb.sv
// Pure combinational RV32I field packer.
// Ports: req (fields + class) in; word (encoded instruction), legal out.
module rv32i_encode_comb
    import rv32i_pkg::*;
(
    input  enc_req_t          req,
    output logic [INST_W-1:0] word,
    output logic              legal
);

    logic [4:0] opcode;
    inst_fmt_e  fmt;
    logic [6:0] op7;
    logic       is_shift;

    // Class -> major opcode and format
    always_comb begin
        opcode = OP_LOAD;
        fmt    = FMT_NONE;
        case (req.cls)
            CLS_LOAD:     begin opcode = OP_LOAD;     fmt = FMT_I; end
            CLS_STORE:    begin opcode = OP_STORE;    fmt = FMT_S; end
            CLS_MEMORDER: begin opcode = OP_MEMORDER; fmt = FMT_I; end
            CLS_ALUREG:   begin opcode = OP_ALUREG;   fmt = FMT_R; end
            CLS_ALUIMM:   begin opcode = OP_ALUIMM;   fmt = FMT_I; end
            CLS_LUI:      begin opcode = OP_LUI;      fmt = FMT_U; end
            CLS_AUIPC:    begin opcode = OP_AUIPC;    fmt = FMT_U; end
            CLS_JAL:      begin opcode = OP_JAL;      fmt = FMT_J; end
            CLS_JALR:     begin opcode = OP_JALR;     fmt = FMT_I; end
            CLS_BRANCH:   begin opcode = OP_BRANCH;   fmt = FMT_B; end
            CLS_SYSCALL:  begin opcode = OP_SYSCALL;  fmt = FMT_I; end
            default:      ;
        endcase
    end

    assign op7      = {opcode, 2'b11};
    // funct3 001/101 on ALUIMM are the shifts: funct7 + 5-bit shamt
    assign is_shift = (req.cls == CLS_ALUIMM) && (req.funct3[1:0] == 2'b01);

    // Field packing and legality per format
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, op7};
                legal = 1'b1;
            end
            FMT_I: begin
                if (is_shift) begin
                    word  = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, op7};
                    legal = (req.imm[31:5] == '0) &&
                            ((req.funct7 == 7'h00) ||
                             ((req.funct7 == 7'h20) && (req.funct3 == 3'b101)));
                end else begin
                    word  = {req.imm[11:0], req.rs1, req.funct3, req.rd, op7};
                    legal = fits_signed(req.imm, 11);
                end
            end
            FMT_S: begin
                word  = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], op7};
                legal = fits_signed(req.imm, 11);
            end
            FMT_B: begin
                word  = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], op7};
                legal = fits_signed(req.imm, 12) && !req.imm[0];
            end
            FMT_U: begin
                word  = {req.imm[31:12], req.rd, op7};
                legal = (req.imm[11:0] == '0);
            end
            FMT_J: begin
                word  = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, op7};
                legal = fits_signed(req.imm, 20) && !req.imm[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_encoder.sv
// RV32I instruction encoder with valid/ready on both sides.
// Ports: clk, rst (async high); inValid/inReady + instruction fields in;
// outValid/outReady, instrOut, outAddr (byte address, +4 per word);
// errFlag (sticky drop) and errCount (saturating drop count).
// Output side is a 2-entry buffer: head drives the outputs, tail holds the second word.
module rv32i_encoder
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_COUNT = 5,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inValid,
    output logic                 inReady,
    input  logic [3:0]           instClass,
    input  logic [REG_COUNT-1:0] rd,
    input  logic [REG_COUNT-1:0] rs1,
    input  logic [REG_COUNT-1:0] rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [XLEN-1:0]      imm,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [XLEN-1:0]      instrOut,
    output logic [ADDR_W-1:0]    outAddr,
    output logic                 errFlag,
    output logic [ERRCNT_W-1:0]  errCount
);

    enc_req_t          req;
    logic [XLEN-1:0]   enc_word;
    logic              enc_legal;

    logic              accept, emit, push, drop;

    logic [XLEN-1:0]   tail_word;
    logic [ADDR_W-1:0] tail_addr;
    logic              tail_valid;
    logic [ADDR_W-1:0] addr_next;

    logic [XLEN-1:0]     head_word_nxt, tail_word_nxt;
    logic [ADDR_W-1:0]   head_addr_nxt, tail_addr_nxt, addr_next_nxt;
    logic                head_valid_nxt, tail_valid_nxt, in_ready_nxt, err_flag_nxt;
    logic [ERRCNT_W-1:0] err_count_nxt;

    assign req.cls    = instClass;
    assign req.rd     = rd;
    assign req.rs1    = rs1;
    assign req.rs2    = rs2;
    assign req.funct3 = funct3;
    assign req.funct7 = funct7;
    assign req.imm    = imm;

    rv32i_encode_comb u_encode (
        .req   (req),
        .word  (enc_word),
        .legal (enc_legal)
    );

    assign accept = inValid & inReady;
    assign emit   = outValid & outReady;
    assign push   = accept & enc_legal;
    assign drop   = accept & ~enc_legal;

    // Buffer, address and error next-state
    always_comb begin
        head_word_nxt  = instrOut;
        head_addr_nxt  = outAddr;
        head_valid_nxt = outValid;
        tail_word_nxt  = tail_word;
        tail_addr_nxt  = tail_addr;
        tail_valid_nxt = tail_valid;
        addr_next_nxt  = addr_next;
        err_flag_nxt   = errFlag;
        err_count_nxt  = errCount;

        // Pop first so a same-cycle push lands in the slot freed behind it
        if (emit) begin
            head_valid_nxt = tail_valid;
            tail_valid_nxt = 1'b0;
            if (tail_valid) begin
                head_word_nxt = tail_word;
                head_addr_nxt = tail_addr;
            end
        end

        if (push) begin
            if (!head_valid_nxt) begin
                head_word_nxt  = enc_word;
                head_addr_nxt  = addr_next;
                head_valid_nxt = 1'b1;
            end else begin
                tail_word_nxt  = enc_word;
                tail_addr_nxt  = addr_next;
                tail_valid_nxt = 1'b1;
            end
            addr_next_nxt = addr_next + ADDR_W'(4);
        end

        if (drop) begin
            err_flag_nxt = 1'b1;
            if (errCount != {ERRCNT_W{1'b1}})
                err_count_nxt = errCount + ERRCNT_W'(1);
        end

        in_ready_nxt = ~(head_valid_nxt & tail_valid_nxt);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrOut   <= '0;
            outAddr    <= '0;
            outValid   <= 1'b0;
            tail_word  <= '0;
            tail_addr  <= '0;
            tail_valid <= 1'b0;
            addr_next  <= '0;
            errFlag    <= 1'b0;
            errCount   <= '0;
            inReady    <= 1'b1;
        end else begin
            instrOut   <= head_word_nxt;
            outAddr    <= head_addr_nxt;
            outValid   <= head_valid_nxt;
            tail_word  <= tail_word_nxt;
            tail_addr  <= tail_addr_nxt;
            tail_valid <= tail_valid_nxt;
            addr_next  <= addr_next_nxt;
            errFlag    <= err_flag_nxt;
            errCount   <= err_count_nxt;
            inReady    <= in_ready_nxt;
        end
    end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: directed vector table plus
// backpressure, drop and mid-operation reset sequences.
module tb_rv32i_encoder;

    typedef struct {
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  instClass = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] instrOut;
    logic [11:0] outAddr;
    logic        errFlag;
    logic [7:0]  errCount;

    int checks = 0;
    int errors = 0;

    logic [11:0] m_addr = '0;
    logic [7:0]  m_cnt  = '0;
    logic        m_flag = 1'b0;

    vec_t vecs [NV];

    rv32i_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .inValid   (inValid),
        .inReady   (inReady),
        .instClass (instClass),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .outValid  (outValid),
        .outReady  (outReady),
        .instrOut  (instrOut),
        .outAddr   (outAddr),
        .errFlag   (errFlag),
        .errCount  (errCount)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] cls, input logic [4:0] vrd, input logic [4:0] vrs1,
                                input logic [4:0] vrs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] vimm, input logic legal, input logic [31:0] word);
        vec_t v;
        v.cls = cls; v.rd = vrd; v.rs1 = vrs1; v.rs2 = vrs2; v.f3 = f3; v.f7 = f7;
        v.imm = vimm; v.legal = legal; v.word = word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instClass = v.cls; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    task automatic model_reset();
        m_addr = '0; m_cnt = '0; m_flag = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        inValid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One request with outReady high; checks the result one cycle after accept
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        inValid  = 1'b1;
        outReady = 1'b1;
        chk({tag, ".inReady"}, 32'(inReady), 32'd1);
        @(negedge clk);
        inValid = 1'b0;
        chk({tag, ".outValid"}, 32'(outValid), 32'(v.legal));
        if (v.legal) begin
            chk({tag, ".instrOut"}, instrOut, v.word);
            chk({tag, ".outAddr"}, 32'(outAddr), 32'(m_addr));
            m_addr = m_addr + 12'd4;
        end else begin
            m_flag = 1'b1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end
        chk({tag, ".errFlag"}, 32'(errFlag), 32'(m_flag));
        chk({tag, ".errCount"}, 32'(errCount), 32'(m_cnt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got_w [3];
        logic [11:0] got_a [3];
        int          ngot;
        int          sent;
        vec_t        seq [3];
        vec_t        bad;

        vecs[0]  = mk(4'd4,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b1, 32'h00500093);
        vecs[1]  = mk(4'd3,  5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        1'b1, 32'h002081B3);
        vecs[2]  = mk(4'd5,  5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1, 32'h123452B7);
        vecs[3]  = mk(4'd7,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        1'b1, 32'h008000EF);
        vecs[4]  = mk(4'd9,  5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3);
        vecs[5]  = mk(4'd0,  5'd2,  5'd3, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 1'b1, 32'hFFF1A103);
        vecs[6]  = mk(4'd1,  5'd0,  5'd2, 5'd5, 3'd2, 7'h00, 32'd8,        1'b1, 32'h00512423);
        vecs[7]  = mk(4'd4,  5'd1,  5'd2, 5'd0, 3'd5, 7'h20, 32'd3,        1'b1, 32'h40315093);
        vecs[8]  = mk(4'd8,  5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 32'd0,        1'b1, 32'h00008067);
        vecs[9]  = mk(4'd6,  5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF000, 1'b1, 32'hFFFFF517);
        vecs[10] = mk(4'd10, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b1, 32'h00000073);
        vecs[11] = mk(4'd2,  5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h000000FF, 1'b1, 32'h0FF0000F);
        vecs[12] = mk(4'd0,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h000007FF, 1'b1, 32'h7FF00083);
        vecs[13] = mk(4'd4,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 1'b1, 32'h80000093);
        vecs[14] = mk(4'd9,  5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000FFE, 1'b1, 32'h7E000FE3);
        vecs[15] = mk(4'd7,  5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFE, 1'b1, 32'hFFFFF06F);
        vecs[16] = mk(4'd4,  5'd1,  5'd1, 5'd0, 3'd1, 7'h20, 32'd1,        1'b0, 32'h0);
        vecs[17] = mk(4'd0,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b0, 32'h0);
        vecs[18] = mk(4'd9,  5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 32'h0);
        vecs[19] = mk(4'd12, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0);
        vecs[20] = mk(4'd5,  5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 1'b0, 32'h0);
        vecs[21] = mk(4'd7,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 1'b0, 32'h0);
        vecs[22] = mk(4'd4,  5'd1,  5'd1, 5'd0, 3'd1, 7'h00, 32'd32,       1'b0, 32'h0);
        vecs[23] = mk(4'd1,  5'd0,  5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFF7FF, 1'b0, 32'h0);
        vecs[24] = mk(4'd15, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'd0,        1'b0, 32'h0);
        vecs[25] = mk(4'd4,  5'd2,  5'd3, 5'd0, 3'd1, 7'h00, 32'd31,       1'b1, 32'h01F19113);
        vecs[26] = mk(4'd7,  5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'd9,        1'b0, 32'h0);

        // Reset state while reset is held
        repeat (2) @(negedge clk);
        chk("rst.outValid", 32'(outValid), 32'd0);
        chk("rst.instrOut", instrOut, 32'd0);
        chk("rst.outAddr",  32'(outAddr), 32'd0);
        chk("rst.errFlag",  32'(errFlag), 32'd0);
        chk("rst.errCount", 32'(errCount), 32'd0);
        chk("rst.inReady",  32'(inReady), 32'd1);
        rst = 1'b0;
        model_reset();

        // Vector table
        for (int i = 0; i < NV; i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: two accepts fill the buffer, drain in order at 0,4,8
        do_reset();
        seq[0] = vecs[0]; seq[1] = vecs[1]; seq[2] = vecs[2];
        ngot = 0;
        sent = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc == 2) chk("bp.inReady_full", 32'(inReady), 32'd0);
            if (cyc == 4) begin
                chk("bp.hold_outValid", 32'(outValid), 32'd1);
                chk("bp.hold_outAddr", 32'(outAddr), 32'd0);
                chk("bp.hold_sent", 32'(sent), 32'd2);
            end
            inValid  = (sent < 3);
            if (sent < 3) drive(seq[sent]);
            outReady = (cyc >= 6);
            if (outValid && outReady && ngot < 3) begin
                got_w[ngot] = instrOut;
                got_a[ngot] = outAddr;
                ngot++;
            end
            if (inValid && inReady) sent++;
        end
        inValid = 1'b0;
        chk("bp.count", 32'(ngot), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < ngot) begin
                chk($sformatf("bp.word%0d", k), got_w[k], seq[k].word);
                chk($sformatf("bp.addr%0d", k), 32'(got_a[k]), 32'(k * 4));
            end
        end

        // Drops do not emit or advance the address
        do_reset();
        apply(mk(4'd9, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3, 1'b0, 32'h0), "drop.branch_odd");
        apply(mk(4'd12, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd0, 1'b0, 32'h0), "drop.class12");
        chk("drop.errCount2", 32'(errCount), 32'd2);
        apply(vecs[3], "drop.next_legal");

        // Reset with two words buffered
        do_reset();
        outReady = 1'b0;
        @(negedge clk); drive(vecs[0]); inValid = 1'b1;
        @(negedge clk); drive(vecs[1]);
        @(negedge clk); inValid = 1'b0;
        chk("mr.full_inReady", 32'(inReady), 32'd0);
        chk("mr.full_outValid", 32'(outValid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr.outValid", 32'(outValid), 32'd0);
        chk("mr.outAddr", 32'(outAddr), 32'd0);
        chk("mr.inReady", 32'(inReady), 32'd1);
        chk("mr.instrOut", instrOut, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply(vecs[2], "mr.next_legal");

        // Error counter saturation
        bad = vecs[19];
        for (int n = 0; n < 260; n++)
            apply(bad, "sat");
        chk("sat.errCount", 32'(errCount), 32'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
